// File: rtl/nf10_pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_pkt_rr_arbiter
//
// Packet-level round-robin arbiter merging NUM_QUEUES AXI4-Stream slave ports
// into one master port. A queue is granted for a whole packet (until the beat
// carrying tlast transfers). One IDLE cycle separates consecutive packets, and
// in that cycle the next grant is chosen. While a packet is in flight, the
// granted slave is wired straight through to the master with zero latency.
//
// Ports
//   axi_aclk, axi_rst         : clock and synchronous active-high reset
//   s_axis_tdata/tstrb/tuser  : slave payloads, queue i occupies slice i
//   s_axis_tvalid/tlast       : per-queue handshake and end-of-packet
//   s_axis_tready             : per-queue ready, only the granted queue sees it
//   m_axis_tdata/tstrb/tuser  : master payload toward the rate limiter
//   m_axis_tvalid/tlast       : master handshake and end-of-packet
//   m_axis_tready             : master backpressure
//   queue_en                  : per-queue arbitration enable
//   pkt_count                 : packets forwarded, modulo 2^32
//   cur_queue                 : currently granted queue index
//   active_pkt                : high while a packet is in flight
// -----------------------------------------------------------------------------
module nf10_pkt_rr_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 4
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_rst,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                       s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                       s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                       s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                       queue_en,
  output logic [31:0]                                 pkt_count,
  output logic [2:0]                                  cur_queue,
  output logic                                        active_pkt
);

  localparam int DW  = C_S_AXIS_DATA_WIDTH;
  localparam int SW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW  = C_S_AXIS_TUSER_WIDTH;
  localparam int MSW = C_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [31:0] pkt_count_q, pkt_count_d;

  // Slave slices unpacked into fixed 8-entry tables so a 3-bit grant can
  // index them directly for any NUM_QUEUES; unused entries read as zero.
  logic [DW-1:0] s_data_a [8];
  logic [SW-1:0] s_strb_a [8];
  logic [UW-1:0] s_user_a [8];
  logic [7:0]    s_valid_ext;
  logic [7:0]    s_last_ext;
  logic [7:0]    en_ext;

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    if (g < NUM_QUEUES) begin : g_used
      assign s_data_a[g]    = s_axis_tdata[g*DW +: DW];
      assign s_strb_a[g]    = s_axis_tstrb[g*SW +: SW];
      assign s_user_a[g]    = s_axis_tuser[g*UW +: UW];
      assign s_valid_ext[g] = s_axis_tvalid[g];
      assign s_last_ext[g]  = s_axis_tlast[g];
      assign en_ext[g]      = queue_en[g];
    end else begin : g_unused
      assign s_data_a[g]    = {DW{1'b0}};
      assign s_strb_a[g]    = {SW{1'b0}};
      assign s_user_a[g]    = {UW{1'b0}};
      assign s_valid_ext[g] = 1'b0;
      assign s_last_ext[g]  = 1'b0;
      assign en_ext[g]      = 1'b0;
    end
  end

  logic [7:0] req_s;
  logic [3:0] arb_cand_s;
  logic       arb_found_s;
  logic [2:0] arb_idx_s;

  // Round-robin search: first requesting queue after last_grant, with wrap.
  always_comb begin
    req_s       = s_valid_ext & en_ext;
    arb_found_s = 1'b0;
    arb_idx_s   = 3'd0;
    arb_cand_s  = 4'd0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      arb_cand_s = {1'b0, last_grant_q} + 4'(k);
      if (arb_cand_s >= 4'(NUM_QUEUES)) begin
        arb_cand_s = arb_cand_s - 4'(NUM_QUEUES);
      end else begin
        arb_cand_s = arb_cand_s;
      end
      if (!arb_found_s && req_s[arb_cand_s[2:0]]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = arb_cand_s[2:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  logic pkt_s;
  logic beat_s;
  logic eop_s;

  // Pass-through datapath. Reset gates the handshake so the beat presented
  // in a reset cycle is not consumed and is resent after reset.
  always_comb begin
    pkt_s         = (state_q == ST_PKT) && !axi_rst;
    m_axis_tdata  = C_M_AXIS_DATA_WIDTH'(s_data_a[grant_q]);
    m_axis_tstrb  = MSW'(s_strb_a[grant_q]);
    m_axis_tuser  = C_M_AXIS_TUSER_WIDTH'(s_user_a[grant_q]);
    m_axis_tvalid = pkt_s && s_valid_ext[grant_q];
    m_axis_tlast  = pkt_s && s_last_ext[grant_q];
    s_axis_tready = {NUM_QUEUES{1'b0}};
    for (int i = 0; i < NUM_QUEUES; i++) begin
      s_axis_tready[i] = pkt_s && m_axis_tready && (grant_q == 3'(i));
    end
    beat_s = m_axis_tvalid && m_axis_tready;
    eop_s  = beat_s && m_axis_tlast;
  end

  // Next-state logic for the IDLE/PKT controller.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          state_d = ST_PKT;
          grant_d = arb_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (eop_s) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          pkt_count_d  = pkt_count_q + 32'd1;
        end else begin
          state_d = ST_PKT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to the top queue so queue 0 goes first.
  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_QUEUES - 1);
      pkt_count_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  // Status outputs, forced quiet while reset is held.
  always_comb begin
    pkt_count  = pkt_count_q;
    active_pkt = pkt_s;
    if (axi_rst) begin
      cur_queue = 3'd0;
    end else begin
      cur_queue = grant_q;
    end
  end

endmodule

// File: tb/tb_nf10_pkt_rr_arbiter.sv
module tb_nf10_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int UW = 128;

  logic              clk;
  logic              axi_rst;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N*DW/8-1:0] s_axis_tstrb;
  logic [N*UW-1:0]   s_axis_tuser;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tlast;
  logic [N-1:0]      s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [N-1:0]      queue_en;
  logic [31:0]       pkt_count;
  logic [2:0]        cur_queue;
  logic              active_pkt;

  nf10_pkt_rr_arbiter #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(N)
  ) dut (
    .axi_aclk(clk), .axi_rst(axi_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .queue_en(queue_en), .pkt_count(pkt_count), .cur_queue(cur_queue), .active_pkt(active_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-queue packet sources: one tag and one last flag per beat.
  logic [31:0] bq_tag  [N][$];
  bit          bq_last [N][$];
  int          vprob = 100;

  // Reference model of the arbiter: packet-granularity round robin.
  bit          m_busy = 1'b0;
  int          m_grant = 0;
  int          m_last = N - 1;
  logic [31:0] m_cnt = 32'd0;

  // Observations collected during step().
  int done_q[$];
  int obs_rdy[N];
  int obs_beats;

  task automatic push_pkt(input int q, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      bq_tag[q].push_back($urandom);
      bq_last[q].push_back(b == nbeats - 1);
    end
  endtask

  task automatic flush();
    for (int q = 0; q < N; q++) begin
      bq_tag[q].delete();
      bq_last[q].delete();
      obs_rdy[q] = 0;
    end
    done_q.delete();
    obs_beats = 0;
  endtask

  task automatic drive_slaves();
    logic [31:0] tag;
    for (int q = 0; q < N; q++) begin
      if (bq_tag[q].size() > 0) begin
        tag              = bq_tag[q][0];
        s_axis_tvalid[q] = ($urandom_range(99) < vprob);
        s_axis_tlast[q]  = bq_last[q][0];
      end else begin
        tag              = 32'd0;
        s_axis_tvalid[q] = 1'b0;
        s_axis_tlast[q]  = 1'b0;
      end
      s_axis_tdata[q*DW +: DW]     = {8{tag}};
      s_axis_tstrb[q*DW/8 +: DW/8] = tag;
      s_axis_tuser[q*UW +: UW]     = {4{~tag}};
    end
  endtask

  // One clock cycle: drive sources, compare DUT against the model, advance.
  task automatic step();
    bit          exp_v;
    logic [N-1:0] exp_rdy;
    logic [31:0] tag;
    bit          hl;
    bit          found;
    int          idx;
    drive_slaves();
    #1;
    exp_v   = m_busy && !axi_rst && s_axis_tvalid[m_grant];
    exp_rdy = (m_busy && !axi_rst && m_axis_tready) ? N'(1 << m_grant) : '0;
    checks++;
    if (m_axis_tvalid !== exp_v) begin
      errors++; $display("FAIL tvalid t=%0t got %b exp %b", $time, m_axis_tvalid, exp_v);
    end
    checks++;
    if (s_axis_tready !== exp_rdy) begin
      errors++; $display("FAIL s_tready t=%0t got %b exp %b", $time, s_axis_tready, exp_rdy);
    end
    checks++;
    if (active_pkt !== (m_busy && !axi_rst)) begin
      errors++; $display("FAIL active_pkt t=%0t got %b exp %b", $time, active_pkt, m_busy && !axi_rst);
    end
    checks++;
    if (cur_queue !== (axi_rst ? 3'd0 : 3'(m_grant))) begin
      errors++; $display("FAIL cur_queue t=%0t got %0d exp %0d", $time, cur_queue, axi_rst ? 0 : m_grant);
    end
    checks++;
    if (pkt_count !== m_cnt) begin
      errors++; $display("FAIL pkt_count t=%0t got %h exp %h", $time, pkt_count, m_cnt);
    end
    if (exp_v) begin
      tag = bq_tag[m_grant][0];
      hl  = bq_last[m_grant][0];
      checks++;
      if (m_axis_tdata !== {8{tag}} || m_axis_tstrb !== tag || m_axis_tuser !== {4{~tag}}) begin
        errors++; $display("FAIL payload t=%0t got %h exp %h", $time, m_axis_tdata[31:0], tag);
      end
      checks++;
      if (m_axis_tlast !== hl) begin
        errors++; $display("FAIL tlast t=%0t got %b exp %b", $time, m_axis_tlast, hl);
      end
    end
    for (int q = 0; q < N; q++) if (s_axis_tready[q] === 1'b1) obs_rdy[q]++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      obs_beats++;
      if (m_axis_tlast === 1'b1) done_q.push_back(int'(cur_queue));
    end
    // Advance model to the state after this rising edge.
    if (axi_rst) begin
      m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_cnt = 32'd0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && s_axis_tvalid[idx] && queue_en[idx]) begin
          found = 1'b1; m_grant = idx; m_busy = 1'b1;
        end
      end
    end else if (s_axis_tvalid[m_grant] && m_axis_tready) begin
      hl = bq_last[m_grant][0];
      void'(bq_tag[m_grant].pop_front());
      void'(bq_last[m_grant].pop_front());
      if (hl) begin
        m_busy = 1'b0; m_last = m_grant; m_cnt = m_cnt + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_test();
    axi_rst = 1'b1;
    flush();
    vprob = 100;
    step();
    axi_rst = 1'b0;
  endtask

  task automatic test_reset();
    axi_rst = 1'b1; queue_en = 4'b1111; m_axis_tready = 1'b1;
    flush();
    push_pkt(0, 2);
    drive_slaves();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 4'b0000) begin
      errors++; $display("FAIL reset_hs got v%b l%b r%b exp 0", m_axis_tvalid, m_axis_tlast, s_axis_tready);
    end
    checks++;
    if (active_pkt !== 1'b0 || cur_queue !== 3'd0 || pkt_count !== 32'd0) begin
      errors++; $display("FAIL reset_status got a%b q%0d c%h exp 0", active_pkt, cur_queue, pkt_count);
    end
    step();
    axi_rst = 1'b0;
  endtask

  task automatic test_single_queue();
    start_test();
    queue_en = 4'b0001; m_axis_tready = 1'b1;
    push_pkt(0, 3);
    for (int c = 0; c < 8; c++) step();
    checks++;
    if (obs_rdy[0] != 3 || obs_beats != 3) begin
      errors++; $display("FAIL single_beats got rdy%0d beats%0d exp 3 3", obs_rdy[0], obs_beats);
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL single_count got %0d exp 1", pkt_count);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    start_test();
    queue_en = 4'b1111; m_axis_tready = 1'b1;
    for (int q = 0; q < N; q++) for (int p = 0; p < 3; p++) push_pkt(q, 1);
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (pkt_count !== 32'd5 || done_q.size() != 5) begin
      errors++; $display("FAIL rr_count got %0d/%0d exp 5", pkt_count, done_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (done_q[i] != exp_order[i]) begin
          errors++; $display("FAIL rr_order idx %0d got %0d exp %0d", i, done_q[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_mask();
    start_test();
    queue_en = 4'b1010; m_axis_tready = 1'b1;
    for (int q = 0; q < N; q++) for (int p = 0; p < 4; p++) push_pkt(q, 1);
    for (int c = 0; c < 16; c++) step();
    checks++;
    if (obs_rdy[0] != 0 || obs_rdy[2] != 0) begin
      errors++; $display("FAIL mask_rdy got q0 %0d q2 %0d exp 0", obs_rdy[0], obs_rdy[2]);
    end
    checks++;
    if (done_q.size() != 8) begin
      errors++; $display("FAIL mask_count got %0d exp 8", done_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (done_q[i] != ((i % 2 == 0) ? 1 : 3)) begin
          errors++; $display("FAIL mask_order idx %0d got %0d exp %0d", i, done_q[i], (i % 2 == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] tag;
    start_test();
    queue_en = 4'b1111; m_axis_tready = 1'b1;
    push_pkt(2, 2);
    tag = bq_tag[2][0];
    step();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      checks++;
      if (active_pkt !== 1'b1 || m_axis_tvalid !== 1'b1 || s_axis_tready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold c%0d got a%b v%b r%b exp 1 1 0000", c, active_pkt, m_axis_tvalid, s_axis_tready);
      end
      checks++;
      if (m_axis_tdata !== {8{tag}}) begin
        errors++; $display("FAIL bp_data c%0d got %h exp %h", c, m_axis_tdata[31:0], tag);
      end
    end
    m_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (pkt_count !== 32'd1 || bq_tag[2].size() != 0) begin
      errors++; $display("FAIL bp_release got %0d left %0d exp 1 0", pkt_count, bq_tag[2].size());
    end
  endtask

  task automatic test_reset_mid();
    int wait_c;
    start_test();
    queue_en = 4'b0010; m_axis_tready = 1'b1;
    push_pkt(1, 4);
    step();
    step();
    axi_rst = 1'b1; queue_en = 4'b0011;
    push_pkt(0, 1);
    step();
    axi_rst = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || active_pkt !== 1'b0 || pkt_count !== 32'd0) begin
      errors++; $display("FAIL rstmid_out got v%b r%b a%b c%0d exp 0", m_axis_tvalid, s_axis_tready, active_pkt, pkt_count);
    end
    wait_c = 0;
    while (active_pkt !== 1'b1 && wait_c < 10) begin
      step(); #1; wait_c++;
    end
    checks++;
    if (active_pkt !== 1'b1 || cur_queue !== 3'd0) begin
      errors++; $display("FAIL rstmid_grant got a%b q%0d exp 1 0", active_pkt, cur_queue);
    end
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (pkt_count !== 32'd2 || bq_tag[1].size() != 0) begin
      errors++; $display("FAIL rstmid_drain got %0d left %0d exp 2 0", pkt_count, bq_tag[1].size());
    end
  endtask

  task automatic test_wrap();
    start_test();
    queue_en = 4'b1111; m_axis_tready = 1'b1;
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step();
    release dut.pkt_count_q;
    step();
    checks++;
    if (pkt_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload got %h exp ffffffff", pkt_count);
    end
    push_pkt(3, 1);
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (pkt_count !== 32'd0) begin
      errors++; $display("FAIL wrap_zero got %h exp 0", pkt_count);
    end
  endtask

  task automatic test_random();
    start_test();
    queue_en = 4'b1111;
    for (int c = 0; c < 1500; c++) begin
      for (int q = 0; q < N; q++) begin
        if (bq_tag[q].size() < 8 && $urandom_range(9) == 0) push_pkt(q, $urandom_range(1, 4));
      end
      if ($urandom_range(49) == 0) queue_en = 4'($urandom);
      m_axis_tready = ($urandom_range(3) != 0);
      vprob         = 80;
      axi_rst       = ($urandom_range(499) == 0);
      step();
    end
    axi_rst = 1'b0;
    checks++;
    if (pkt_count !== m_cnt) begin
      errors++; $display("FAIL random_count got %0d exp %0d", pkt_count, m_cnt);
    end
  endtask

  initial begin
    axi_rst = 1'b1; queue_en = '0; m_axis_tready = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_queue();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_pkt_rr_arbiter.md
NF10_PKT_RR_ARBITER -- requirements
Module: nf10_pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256: data width of the master stream.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256: data width of each slave stream; it equals C_M_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128: tuser width of the master stream.
REQ-004 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128: tuser width of each slave stream.
REQ-005 SHALL have parameter NUM_QUEUES, default 4: number of slave streams, range 2..8.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports as follows: axi_aclk, in, 1, the single clock; all logic is on its rising edge.
REQ-007 axi_rst  in  1  synchronous active-high reset.
REQ-008 s_axis_tdata  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH  slave data, with queue i at slice i.
REQ-009 s_axis_tstrb  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8  slave byte strobes, sliced per queue.
REQ-010 s_axis_tuser  in  NUM_QUEUES*C_S_AXIS_TUSER_WIDTH  slave tuser, sliced per queue.
REQ-011 s_axis_tvalid / s_axis_tlast  in  NUM_QUEUES  per-queue valid and last; s_axis_tready  out  NUM_QUEUES  per-queue ready.
REQ-012 m_axis_tdata / tstrb / tuser  out  C_M_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH/8 / C_M_AXIS_TUSER_WIDTH  master payload toward the rate limiter.
REQ-013 m_axis_tvalid / m_axis_tlast  out  1 each; m_axis_tready  in  1.
REQ-014 queue_en  in  NUM_QUEUES  per-queue arbitration enable, driven from a register.
REQ-015 pkt_count  out  32  count of packets forwarded, modulo 2^32.
REQ-016 cur_queue  out  3  index of the queue currently granted; active_pkt  out  1  high while in state PKT.

Function
REQ-017 SHALL have two states: IDLE and PKT.
REQ-018 In IDLE, the request vector SHALL be req = s_axis_tvalid & queue_en.
REQ-019 In IDLE, when req != 0, the arbiter SHALL register grant = the first set bit of req searched from (last_grant+1) mod NUM_QUEUES upward with wrap, and go to PKT on the next cycle.
REQ-020 In IDLE, all s_axis_tready bits and m_axis_tvalid SHALL be 0, so no beat transfers in the arbitration cycle.
REQ-021 In PKT, the master payload, tvalid and tlast SHALL be combinational copies of slave slice [grant].
REQ-022 In PKT, s_axis_tready[grant] SHALL equal m_axis_tready, and all other ready bits SHALL be 0.
REQ-023 A beat transfers when m_axis_tvalid & m_axis_tready; the latency from slave to master is 0 cycles within PKT.
REQ-024 On a transferred beat with tlast=1: the state SHALL return to IDLE, last_grant SHALL take the value grant, and pkt_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-025 There SHALL be exactly one IDLE bubble cycle between consecutive packets.
REQ-026 A single-beat packet SHALL occupy one PKT cycle when m_axis_tready=1.
REQ-027 A queue_en change during PKT SHALL NOT abort the current packet; the change takes effect at the next IDLE.
REQ-028 If s_axis_tvalid[grant] drops mid-packet, the arbiter SHALL stay in PKT with m_axis_tvalid=0 and SHALL NOT re-arbitrate.
REQ-029 If m_axis_tready=0, the arbiter SHALL hold in PKT; no slave beat is consumed.
REQ-030 When req == 0 in IDLE, the arbiter SHALL stay in IDLE and last_grant SHALL be unchanged.
REQ-031 A queue with valid=1 and queue_en=0 SHALL never be granted and SHALL see tready=0.
REQ-032 Starvation bound: an enabled, requesting queue SHALL be granted within NUM_QUEUES-1 other packets.
REQ-033 cur_queue SHALL equal grant, zero-extended to 3 bits; active_pkt SHALL be 1 exactly when state == PKT.

Reset
REQ-034 While axi_rst=1 at a clock edge, the block SHALL set state=IDLE, grant=0, last_grant=NUM_QUEUES-1 (so queue 0 has first priority) and pkt_count=0.
REQ-035 During reset, m_axis_tvalid, m_axis_tlast, all s_axis_tready bits and active_pkt SHALL be 0, and cur_queue SHALL be 0.
REQ-036 A reset asserted mid-packet SHALL abandon that packet without incrementing pkt_count; the remaining beats of that packet SHALL be treated as a new packet after reset.

Verification
REQ-037 Single queue: queue_en=4'b0001, 3-beat packet on q0, m_axis_tready=1 -> IDLE cycle, then 3 master beats with tlast on the 3rd, q0 tready high for 3 cycles, pkt_count=1.
REQ-038 Round-robin: after reset, all 4 queues hold 1-beat packets and stay valid -> grant order 0,1,2,3,0; master tvalid pattern 0,1,0,1,...; pkt_count=5 after 10 cycles.
REQ-039 Mask: queue_en=4'b1010, all queues valid -> only q1 and q3 are granted, alternating; s_axis_tready[0] and s_axis_tready[2] never go to 1.
REQ-040 Backpressure: in PKT on q2, hold m_axis_tready=0 for 5 cycles -> m_axis_tvalid=1, s_axis_tready=0, data stable, state stays PKT; on release the beat transfers.
REQ-041 Reset mid-packet: axi_rst for 1 cycle at beat 2 of a 4-beat packet on q1 -> outputs 0 on the next cycle, pkt_count=0, next grant goes to q0 if q0 is requesting.
REQ-042 Wrap: preload pkt_count to 0xFFFFFFFF by forcing or running packets, then send 1 more packet -> pkt_count=0.
